// File: rtl/gpu_pkg.sv
// gpu_pkg: shared sprite-scheduler state encoding and default sizing
package gpu_pkg;
  localparam int NUM_SPR_D = 128;
  localparam int MAX_PER_LINE_D = 32;
  localparam int CLR_WORDS_D = 64;
  localparam int ATTR_LAT_D = 2;
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WAIT, TEST, REQ, XFER} spr_state_t;
endpackage

// File: rtl/gpu_spr_hit.sv
// gpu_spr_hit: sprite vertical hit test, 9-bit modulo distance under 16
module gpu_spr_hit (
  input  logic [8:0] line_y,
  input  logic [8:0] attr_x,
  output logic       hit
);
  logic [8:0] d;
  assign d = (line_y ^ 9'h0FF) - attr_x;
  assign hit = d < 9'd16;
endmodule

// File: rtl/gpu_spr_sched.sv
// gpu_spr_sched: per-line sprite scan that clears the line FIFO and issues sprite DMA fetches
module gpu_spr_sched
  import gpu_pkg::*;
#(
  parameter int NUM_SPR = NUM_SPR_D,
  parameter int MAX_PER_LINE = MAX_PER_LINE_D,
  parameter int CLR_WORDS = CLR_WORDS_D,
  parameter int ATTR_LAT = ATTR_LAT_D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_start,
  input  logic       dma_ena,
  input  logic [8:0] line_y,
  output logic [6:0] attr_addr,
  input  logic [8:0] attr_x,
  output logic       fifo_clr,
  output logic       dma_req,
  input  logic       dma_ack,
  input  logic       dma_done,
  output logic [5:0] line_cnt,
  output logic       ovf,
  output logic       busy
);
  localparam int CW = $clog2(CLR_WORDS > ATTR_LAT ? CLR_WORDS : ATTR_LAT) + 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WORDS - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(ATTR_LAT - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [5:0] MAX_C = 6'(MAX_PER_LINE);
  localparam logic [6:0] TOP_SLOT = 7'(NUM_SPR - 1);
  spr_state_t state, state_n;
  logic [6:0] slot, slot_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [5:0] lcnt_n;
  logic ovf_n, pend, pend_n, stop, stop_n, hit, go_clr, advance;
  gpu_spr_hit u_hit (.line_y(line_y), .attr_x(attr_x), .hit(hit));
  assign attr_addr = slot;
  assign fifo_clr = state == CLEAR;
  assign dma_req = state == REQ;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      slot <= '0;
      cnt <= '0;
      line_cnt <= '0;
      ovf <= 1'b0;
      pend <= 1'b0;
      stop <= 1'b0;
    end else begin
      state <= state_n;
      slot <= slot_n;
      cnt <= cnt_n;
      line_cnt <= lcnt_n;
      ovf <= ovf_n;
      pend <= pend_n;
      stop <= stop_n;
    end
  end
  // pend/stop remember a restart or disable seen mid-handshake until dma_done
  always_comb begin
    state_n = state;
    slot_n = slot;
    cnt_n = cnt;
    lcnt_n = line_cnt;
    ovf_n = ovf;
    pend_n = pend;
    stop_n = stop;
    go_clr = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE: if (line_start && dma_ena) begin
        go_clr = 1'b1;
        ovf_n = 1'b0;
      end
      REQ, XFER: begin
        pend_n = pend | line_start;
        stop_n = stop | ~dma_ena;
        ovf_n = ovf | line_start;
        if (state == REQ && dma_ack) begin
          state_n = XFER;
          lcnt_n = line_cnt + 6'd1;
        end
        if (state == XFER && dma_done) begin
          if (stop_n) state_n = IDLE;
          else if (pend_n) go_clr = 1'b1;
          else advance = 1'b1;
        end
      end
      default:
        if (!dma_ena) state_n = IDLE;
        else if (line_start) begin
          ovf_n = 1'b1;
          go_clr = 1'b1;
        end else case (state)
          CLEAR: begin
            state_n = cnt == CLR_LAST ? FETCH : CLEAR;
            cnt_n = cnt + ONE;
          end
          FETCH: begin
            state_n = WAIT;
            cnt_n = '0;
          end
          WAIT: begin
            state_n = cnt == LAT_LAST ? TEST : WAIT;
            cnt_n = cnt + ONE;
          end
          TEST:
            if (!hit) advance = 1'b1;
            else if (line_cnt == MAX_C) begin
              ovf_n = 1'b1;
              state_n = IDLE;
            end else state_n = REQ;
          default: ;
        endcase
    endcase
    if (advance) begin
      state_n = slot == '0 ? IDLE : FETCH;
      slot_n = slot == '0 ? slot : slot - 7'd1;
    end
    if (go_clr) begin
      state_n = CLEAR;
      cnt_n = '0;
      slot_n = TOP_SLOT;
      lcnt_n = '0;
      pend_n = 1'b0;
      stop_n = 1'b0;
    end
  end
endmodule

// File: tb/tb_gpu_spr_sched.sv
// tb_gpu_spr_sched: table-driven line scans plus directed handshake corner cases
module tb_gpu_spr_sched;
  logic clk = 1'b0, rst = 1'b1, line_start = 1'b0, dma_ena = 1'b1, dma_ack = 1'b0, dma_done = 1'b0;
  logic [8:0] line_y = 9'h0F0;
  logic [8:0] attr_x;
  logic [6:0] attr_addr;
  logic fifo_clr, dma_req, ovf, busy;
  logic [5:0] line_cnt;
  logic [8:0] mem [128];
  logic [6:0] a1 = '0, a2 = '0;
  int n_cmp = 0, n_bad = 0, ack_dly = 1, done_dly = 1, acks = 0;

  typedef struct {
    logic [8:0] y, xh, xm;
    int nhit;
    logic [5:0] cnt;
    logic ovf;
  } vec_t;
  vec_t v[6];

  gpu_spr_sched dut (
    .clk(clk), .rst(rst), .line_start(line_start), .dma_ena(dma_ena), .line_y(line_y),
    .attr_addr(attr_addr), .attr_x(attr_x), .fifo_clr(fifo_clr), .dma_req(dma_req),
    .dma_ack(dma_ack), .dma_done(dma_done), .line_cnt(line_cnt), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // attribute RAM with two-cycle read latency
  always @(posedge clk) begin
    a1 <= attr_addr;
    a2 <= a1;
  end
  assign attr_x = mem[a2];

  // DMA responder: ack after ack_dly request cycles, done done_dly cycles later
  initial begin
    forever begin
      @(posedge clk); #2;
      if (dma_req) begin
        repeat (ack_dly - 1) begin @(posedge clk); #2; end
        dma_ack = 1'b1;
        acks++;
        @(posedge clk); #2;
        dma_ack = 1'b0;
        repeat (done_dly - 1) begin @(posedge clk); #2; end
        dma_done = 1'b1;
        @(posedge clk); #2;
        dma_done = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill(input int nhit, input logic [8:0] xh, input logic [8:0] xm);
    for (int i = 0; i < 128; i++) mem[i] = i < nhit ? xh : xm;
  endtask

  task automatic start_line();
    @(negedge clk);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic count_clr(output int n);
    n = 0;
    while (fifo_clr && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk(nm, busy, 0);
  endtask

  initial begin
    int n;
    int bad;
    // hit windows: line_y^0FF minus attr_x in [0,15] mod 512
    v[0] = '{9'h0F0, 9'h000, 9'h0F0, 128, 6'd32, 1'b1};
    v[1] = '{9'h0F0, 9'h000, 9'h0F0, 0, 6'd0, 1'b0};
    v[2] = '{9'h000, 9'h0F0, 9'h100, 7, 6'd7, 1'b0};
    v[3] = '{9'h0FF, 9'h1F1, 9'h1F0, 32, 6'd32, 1'b0};
    v[4] = '{9'h0FF, 9'h1F1, 9'h1F0, 33, 6'd32, 1'b1};
    v[5] = '{9'h0F0, 9'h00F, 9'h010, 3, 6'd3, 1'b0};
    fill(0, 9'h000, 9'h0F0);
    repeat (3) @(negedge clk);
    chk("reset outputs", {attr_addr, fifo_clr, dma_req, line_cnt, ovf, busy}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      line_y = v[i].y;
      fill(v[i].nhit, v[i].xh, v[i].xm);
      acks = 0;
      start_line();
      count_clr(n);
      chk($sformatf("v%0d clr_words", i), n, 64);
      wait_idle($sformatf("v%0d idle", i));
      chk($sformatf("v%0d line_cnt", i), line_cnt, v[i].cnt);
      chk($sformatf("v%0d ovf", i), ovf, v[i].ovf);
      chk($sformatf("v%0d requests", i), acks, v[i].cnt);
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d hold", i), {line_cnt, ovf}, {v[i].cnt, v[i].ovf});
    end

    // reset mid-CLEAR
    line_y = 9'h0F0;
    fill(0, 9'h000, 9'h0F0);
    start_line();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst mid-clear", {attr_addr, fifo_clr, dma_req, line_cnt, ovf, busy}, 0);

    // single hit at slot 5, slow ack
    mem[5] = 9'h000;
    ack_dly = 10;
    done_dly = 3;
    acks = 0;
    start_line();
    n = 0;
    while (!dma_req && n < 2000) begin n++; @(negedge clk); end
    chk("slow ack req seen", dma_req, 1);
    n = 0;
    bad = 0;
    while (dma_req && n < 100) begin
      n++;
      if (attr_addr !== 7'd5) bad++;
      @(negedge clk);
    end
    chk("slow ack req width", n, 10);
    chk("slow ack addr stray", bad, 0);
    n = 0;
    while (!dma_done && n < 100) begin n++; @(negedge clk); end
    chk("slow ack done seen", dma_done, 1);
    @(negedge clk);
    chk("resume slot", attr_addr, 4);
    wait_idle("slow ack idle");
    chk("slow ack line_cnt", line_cnt, 1);
    chk("slow ack ovf", ovf, 0);

    // line_start during XFER
    ack_dly = 1;
    done_dly = 5;
    start_line();
    n = 0;
    while (!dma_ack && n < 2000) begin n++; @(negedge clk); end
    chk("xfer ack seen", dma_ack, 1);
    @(negedge clk);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    n = 0;
    while (!dma_done && n < 100) begin n++; @(negedge clk); end
    chk("xfer done seen", dma_done, 1);
    @(negedge clk);
    chk("restart clear", fifo_clr, 1);
    chk("restart ovf", ovf, 1);
    count_clr(n);
    chk("restart clr_words", n, 64);
    done_dly = 1;
    wait_idle("restart idle");

    // dma_ena dropped during WAIT
    fill(128, 9'h000, 9'h0F0);
    acks = 0;
    start_line();
    count_clr(n);
    chk("ena clr_words", n, 64);
    @(negedge clk);
    dma_ena = 1'b0;
    @(negedge clk);
    chk("ena drop idle", busy, 0);
    repeat (8) @(negedge clk);
    chk("ena drop no req", {dma_req, acks[7:0]}, 0);

    // line_start ignored while disabled
    start_line();
    chk("disabled start", busy, 0);
    dma_ena = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
